servant_extmem_loader: RTL and testbench
========================================

SERVANT_EXTMEM_LOADER -- requirements
Module: servant_extmem_loader

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the transfer-length field.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for i_wb_ack per transaction; used only when SERVANT_EXTMEM_LOADER_TIMEOUT_EN is defined.
REQ-003 SHALL have i_wb_clk input 1: single clock; all logic on its rising edge.
REQ-004 SHALL have i_wb_rst input 1: reset, synchronous and active-high.
REQ-005 SHALL have i_start input 1: one-cycle command strobe.
REQ-006 SHALL have i_dir input 1: transfer direction; 0 = load (stream to memory), 1 = dump (memory to stream).
REQ-007 SHALL have i_base_adr input 32: byte address of the first word.
REQ-008 SHALL have i_len input LEN_W: number of bytes to transfer.
REQ-009 SHALL have i_s_data input 8, i_s_valid input 1 and o_s_ready output 1: load stream.
REQ-010 SHALL have o_m_data output 8, o_m_valid output 1 and i_m_ready input 1: dump stream.
REQ-011 SHALL have o_wb_adr output 32, o_wb_dat output 32, o_wb_we output 1 and o_wb_cyc output 1: Wishbone initiator request.
REQ-012 SHALL have i_wb_rdt input 32 and i_wb_ack input 1: Wishbone response.
REQ-013 SHALL have o_busy output 1, o_done output 1 and o_err output 1: status.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, REQ, GAP, PUSH and DONE.
REQ-015 SHALL, in IDLE on i_start with i_len != 0, latch i_dir, i_base_adr and i_len and go to FETCH (load) or REQ (dump).
REQ-016 SHALL, in IDLE on i_start with i_len == 0, go to DONE; no bus cycle is issued.
REQ-017 SHALL ignore i_start outside IDLE.
REQ-018 SHALL, in FETCH, assert o_s_ready; on i_s_valid & o_s_ready, capture the byte and go to REQ.
REQ-019 SHALL, in REQ, hold o_wb_cyc=1, o_wb_we=dir==0, o_wb_adr = base + 4*index and o_wb_dat = {24'h0, byte}, all stable until i_wb_ack.
REQ-020 SHALL, on i_wb_ack in REQ, drop o_wb_cyc on the next edge and, for a dump, capture i_wb_rdt[7:0].
REQ-021 SHALL, after a load ack, go to GAP; after a dump ack, go to PUSH.
REQ-022 SHALL keep o_wb_cyc low for exactly one cycle in GAP, which clears the responder ack pipeline.
REQ-023 SHALL, in PUSH, assert o_m_valid with o_m_data stable until i_m_ready, then go to GAP.
REQ-024 SHALL, leaving GAP, increment index, then go to DONE if index == len, otherwise to FETCH (load) or REQ (dump).
REQ-025 SHALL use a LEN_W-bit index; address arithmetic is 32-bit modulo 2^32, so wrap past 0xFFFFFFFC is permitted.
REQ-026 SHALL, in DONE, pulse o_done for exactly one cycle, then return to IDLE.
REQ-027 SHALL assert o_busy in every state except IDLE.
REQ-028 SHALL accept ack latency of at least 1 cycle; the existing external-memory responder acks 3 cycles after o_wb_cyc rises.

Reset
REQ-029 SHALL, on i_wb_rst, enter IDLE and drive o_wb_cyc, o_wb_we, o_s_ready, o_m_valid, o_busy, o_done and o_err to 0, and o_wb_adr, o_wb_dat and o_m_data to 0, on the next edge.
REQ-030 SHALL, on reset mid-transfer, abandon the transfer with o_wb_cyc low the following cycle and no o_done.

Configuration
REQ-031 SHALL, with SERVANT_EXTMEM_LOADER_TIMEOUT_EN defined, count cycles in REQ, and if TIMEOUT_CYCLES elapse without ack, drop o_wb_cyc, set o_err (sticky until the next accepted i_start) and go to DONE.
REQ-032 SHALL, without SERVANT_EXTMEM_LOADER_TIMEOUT_EN, wait indefinitely in REQ, tie o_err to 0 and synthesize no counter.

Structure
REQ-033 SHALL take the state encoding enum and the DIR_LOAD/DIR_DUMP constants from shared package servant_extmem_pkg.
REQ-034 SHALL instantiate no sub-modules; the optional watchdog is inline logic.

Verification
REQ-035 SHALL cover load: base 0x100, len 4, bytes A1..A4 -> writes to 0x100/0x104/0x108/0x10C with dat 0x000000A1..A4, then one o_done pulse.
REQ-036 SHALL cover dump with responder preloaded 0x11,0x22,0x33 and i_m_ready low for 5 cycles on the second byte -> stream 11,22,33 in order, o_m_data stable while stalled.
REQ-037 SHALL cover len 0: i_start -> o_done one cycle later and o_wb_cyc never asserted.
REQ-038 SHALL cover i_start pulsed during a busy load of len 2 -> ignored; exactly 2 writes occur.
REQ-039 SHALL cover i_wb_rst asserted in REQ of the second load word -> o_wb_cyc 0 next cycle, o_busy 0, no o_done.
REQ-040 SHALL cover timeout (macro defined, TIMEOUT_CYCLES=8, ack never returned) -> o_wb_cyc dropped after 8 cycles, o_err=1, o_done pulse.

Source files
------------

// File: rtl/servant_extmem_pkg.sv
// Shared definitions for the servant external-memory loader: FSM state
// encoding, transfer-direction constants and the word-address helper.
package servant_extmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_REQ   = 3'd2,
    ST_GAP   = 3'd3,
    ST_PUSH  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic DIR_LOAD = 1'b0;
  localparam logic DIR_DUMP = 1'b1;

  // Byte address of word number idx; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_adr(input logic [31:0] base,
                                           input logic [31:0] idx);
    word_adr = base + (idx << 2);
  endfunction

endpackage

// File: rtl/servant_extmem_loader.sv
// servant_extmem_loader: moves a byte stream into word-spaced external memory
// (load) or reads it back out as a byte stream (dump) over Wishbone.
// One byte per 32-bit word, one bus cycle at a time, with a one-cycle gap
// between cycles so the responder's ack pipeline drains.
// Optional: define SERVANT_EXTMEM_LOADER_TIMEOUT_EN to add an ack watchdog
// that aborts a transfer with a sticky o_err.
module servant_extmem_loader
  import servant_extmem_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic [31:0]      i_base_adr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [7:0]       o_m_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [31:0]      o_wb_adr,
  output logic [31:0]      o_wb_dat,
  output logic             o_wb_we,
  output logic             o_wb_cyc,
  input  logic [31:0]      i_wb_rdt,
  input  logic             i_wb_ack,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [31:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;

  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef SERVANT_EXTMEM_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Upper read-data bits carry nothing for a byte-wide dump.
  logic unused_s;
  assign unused_s = ^{i_wb_rdt[31:8], (TIMEOUT_CYCLES != 0)};

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
`ifdef SERVANT_EXTMEM_LOADER_TIMEOUT_EN
    err_d   = err_q;
    // The watchdog only runs while a bus cycle is outstanding.
    if (state_q == ST_REQ) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = {TMO_W{1'b0}};
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
`ifdef SERVANT_EXTMEM_LOADER_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (i_len != {LEN_W{1'b0}}) begin
            dir_d   = i_dir;
            base_d  = i_base_adr;
            len_d   = i_len;
            idx_d   = {LEN_W{1'b0}};
            state_d = (i_dir == DIR_LOAD) ? ST_FETCH : ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (i_s_valid && s_ready_q) begin
          byte_d  = i_s_data;
          state_d = ST_REQ;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_REQ: begin
        if (i_wb_ack) begin
          if (dir_q == DIR_DUMP) begin
            byte_d  = i_wb_rdt[7:0];
            state_d = ST_PUSH;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
`ifdef SERVANT_EXTMEM_LOADER_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_PUSH: begin
        if (i_m_ready && m_valid_q) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_PUSH;
        end
      end
      ST_GAP: begin
        idx_d = idx_q + {{(LEN_W-1){1'b0}}, 1'b1};
        if (idx_d == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = (dir_q == DIR_LOAD) ? ST_FETCH : ST_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered images of the state being entered, so every
    // bus/stream signal changes only on a clock edge and is held stable.
    cyc_d     = (state_d == ST_REQ);
    we_d      = (state_d == ST_REQ) && (dir_d == DIR_LOAD);
    s_ready_d = (state_d == ST_FETCH);
    m_valid_d = (state_d == ST_PUSH);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);

    if (state_d == ST_REQ) begin
      adr_d = word_adr(base_d, 32'(idx_d));
      dat_d = {24'h000000, byte_d};
    end else begin
      adr_d = adr_q;
      dat_d = dat_q;
    end

    if (state_d == ST_PUSH) begin
      m_data_d = byte_d;
    end else begin
      m_data_d = m_data_q;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_LOAD;
      base_q    <= 32'h0000_0000;
      len_q     <= {LEN_W{1'b0}};
      idx_q     <= {LEN_W{1'b0}};
      byte_q    <= 8'h00;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 32'h0000_0000;
      dat_q     <= 32'h0000_0000;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERVANT_EXTMEM_LOADER_TIMEOUT_EN
      tmo_q     <= {TMO_W{1'b0}};
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SERVANT_EXTMEM_LOADER_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign o_wb_cyc  = cyc_q;
  assign o_wb_we   = we_q;
  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_s_ready = s_ready_q;
  assign o_m_valid = m_valid_q;
  assign o_m_data  = m_data_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
`ifdef SERVANT_EXTMEM_LOADER_TIMEOUT_EN
  assign o_err     = err_q;
`else
  assign o_err     = 1'b0;
`endif

endmodule

// File: tb/tb_servant_extmem_loader.sv
// Directed self-checking bench for servant_extmem_loader with a Wishbone
// responder that acks 3 cycles after o_wb_cyc rises.
module tb_servant_extmem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [31:0] base_adr = 32'h0;
  logic [15:0] len = 16'h0;
  logic [7:0]  s_data = 8'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] wb_adr, wb_dat, wb_rdt;
  logic        wb_we, wb_cyc, wb_ack;
  logic        busy, done, err;

  always #5 clk = ~clk;

  servant_extmem_loader #(.LEN_W(16), .TIMEOUT_CYCLES(8)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_start(start), .i_dir(dir),
    .i_base_adr(base_adr), .i_len(len),
    .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .o_m_data(m_data), .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
    .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Responder / monitor state.
  logic [31:0] mem [16];
  logic        resp_en = 1'b1;
  int          cnt = 0;
  logic [31:0] wr_adr [32];
  logic [31:0] wr_dat [32];
  int          wr_n = 0;
  logic [7:0]  rx [32];
  int          rx_n = 0;
  int          done_cnt = 0;
  int          done_run = 0;
  int          max_run = 0;
  int          cyc_hi = 0;

  initial wb_ack = 1'b0;
  initial wb_rdt = 32'h0;

  // Wishbone responder plus bus/stream/status monitors.
  always @(posedge clk) begin
    wb_ack <= 1'b0;
    if (wb_cyc && !wb_ack && resp_en) begin
      if (cnt == 2) begin
        wb_ack <= 1'b1;
        wb_rdt <= mem[wb_adr[5:2]];
        cnt    <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
    if (wb_cyc && wb_ack && wb_we && wr_n < 32) begin
      wr_adr[wr_n] <= wb_adr;
      wr_dat[wr_n] <= wb_dat;
      wr_n <= wr_n + 1;
    end
    if (m_valid && m_ready && rx_n < 32) begin
      rx[rx_n] <= m_data;
      rx_n <= rx_n + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_run <= done_run + 1;
      if (done_run + 1 > max_run) max_run <= done_run + 1;
    end else begin
      done_run <= 0;
    end
    if (wb_cyc) cyc_hi <= cyc_hi + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic d, input logic [31:0] b,
                           input logic [15:0] l);
    @(negedge clk);
    dir = d; base_adr = b; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic found;
    found = 1'b0;
    s_data = b; s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (s_ready) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("s_ready_seen", {31'h0, found}, 32'h1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int   snap;
    logic found;
    snap = done_cnt; found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_cnt != snap) begin found = 1'b1; break; end
    end
    check_eq(tag, {31'h0, found}, 32'h1);
  endtask

  task automatic wait_mvalid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check_eq(tag, {31'h0, found}, 32'h1);
  endtask

  initial begin
    int w0, d0, c0, r0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEAD_BE11;
    mem[1] = 32'hCAFE_0022;
    mem[2] = 32'h1234_5633;

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy",   {31'h0, busy},    32'h0);
    check_eq("rst_done",   {31'h0, done},    32'h0);
    check_eq("rst_cyc",    {31'h0, wb_cyc},  32'h0);
    check_eq("rst_we",     {31'h0, wb_we},   32'h0);
    check_eq("rst_sready", {31'h0, s_ready}, 32'h0);
    check_eq("rst_mvalid", {31'h0, m_valid}, 32'h0);
    check_eq("rst_err",    {31'h0, err},     32'h0);
    check_eq("rst_adr",    wb_adr,           32'h0);
    check_eq("rst_dat",    wb_dat,           32'h0);
    check_eq("rst_mdata",  {24'h0, m_data},  32'h0);

    // Load 4 bytes to 0x100.
    w0 = wr_n; d0 = done_cnt;
    start_cmd(1'b0, 32'h0000_0100, 16'd4);
    check_eq("load_busy", {31'h0, busy}, 32'h1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    wait_done("load_done_seen");
    @(negedge clk);
    check_eq("load_nwr", wr_n - w0, 32'd4);
    check_eq("load_adr0", wr_adr[w0],   32'h0000_0100);
    check_eq("load_adr1", wr_adr[w0+1], 32'h0000_0104);
    check_eq("load_adr2", wr_adr[w0+2], 32'h0000_0108);
    check_eq("load_adr3", wr_adr[w0+3], 32'h0000_010C);
    check_eq("load_dat0", wr_dat[w0],   32'h0000_00A1);
    check_eq("load_dat1", wr_dat[w0+1], 32'h0000_00A2);
    check_eq("load_dat2", wr_dat[w0+2], 32'h0000_00A3);
    check_eq("load_dat3", wr_dat[w0+3], 32'h0000_00A4);
    check_eq("load_ndone", done_cnt - d0, 32'd1);
    check_eq("load_idle", {31'h0, busy}, 32'h0);

    // Dump 3 words from 0x200 with a 5-cycle stall on the second byte.
    r0 = rx_n;
    m_ready = 1'b0;
    start_cmd(1'b1, 32'h0000_0200, 16'd3);
    wait_mvalid("dump_v0");
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    wait_mvalid("dump_v1");
    for (int i = 0; i < 5; i++) begin
      check_eq("dump_stall_data",  {24'h0, m_data}, 32'h22);
      check_eq("dump_stall_valid", {31'h0, m_valid}, 32'h1);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    wait_mvalid("dump_v2");
    m_ready = 1'b1;
    wait_done("dump_done_seen");
    m_ready = 1'b0;
    check_eq("dump_nrx", rx_n - r0, 32'd3);
    check_eq("dump_b0", {24'h0, rx[r0]},   32'h11);
    check_eq("dump_b1", {24'h0, rx[r0+1]}, 32'h22);
    check_eq("dump_b2", {24'h0, rx[r0+2]}, 32'h33);
`ifndef SERVANT_EXTMEM_LOADER_TIMEOUT_EN
    check_eq("dump_err", {31'h0, err}, 32'h0);
`endif

    // Zero length: immediate done, no bus cycle.
    repeat (2) @(negedge clk);
    c0 = cyc_hi;
    @(negedge clk);
    dir = 1'b0; base_adr = 32'h0000_0500; len = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("len0_done", {31'h0, done}, 32'h1);
    check_eq("len0_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check_eq("len0_done_off", {31'h0, done}, 32'h0);
    repeat (3) @(negedge clk);
    check_eq("len0_nocyc", cyc_hi - c0, 32'd0);

    // Start pulsed while busy is ignored.
    w0 = wr_n; d0 = done_cnt;
    start_cmd(1'b0, 32'h0000_0300, 16'd2);
    start_cmd(1'b1, 32'h0000_0800, 16'd5);
    send_byte(8'h5A);
    start_cmd(1'b0, 32'h0000_0900, 16'd7);
    send_byte(8'hC3);
    wait_done("busy_done_seen");
    repeat (20) @(negedge clk);
    check_eq("busy_nwr",  wr_n - w0, 32'd2);
    check_eq("busy_adr0", wr_adr[w0],   32'h0000_0300);
    check_eq("busy_adr1", wr_adr[w0+1], 32'h0000_0304);
    check_eq("busy_dat1", wr_dat[w0+1], 32'h0000_00C3);
    check_eq("busy_ndone", done_cnt - d0, 32'd1);

    // Reset while the second load word is on the bus.
    w0 = wr_n; d0 = done_cnt;
    start_cmd(1'b0, 32'h0000_0400, 16'd3);
    send_byte(8'h01);
    send_byte(8'h02);
    check_eq("rstmid_cyc_pre", {31'h0, wb_cyc}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid_cyc",  {31'h0, wb_cyc}, 32'h0);
    check_eq("rstmid_busy", {31'h0, busy},   32'h0);
    rst = 1'b0;
    c0 = cyc_hi;
    repeat (10) @(negedge clk);
    check_eq("rstmid_nodone", done_cnt - d0, 32'd0);
    check_eq("rstmid_nocyc",  cyc_hi - c0,   32'd0);
    check_eq("rstmid_nwr",    wr_n - w0,     32'd1);

`ifdef SERVANT_EXTMEM_LOADER_TIMEOUT_EN
    // Ack never returns: watchdog aborts after 8 cycles.
    resp_en = 1'b0;
    d0 = done_cnt;
    start_cmd(1'b0, 32'h0000_0600, 16'd1);
    c0 = cyc_hi;
    send_byte(8'h77);
    wait_done("tmo_done_seen");
    @(negedge clk);
    check_eq("tmo_cyc_cycles", cyc_hi - c0, 32'd8);
    check_eq("tmo_err",   {31'h0, err},    32'h1);
    check_eq("tmo_cyc",   {31'h0, wb_cyc}, 32'h0);
    check_eq("tmo_ndone", done_cnt - d0,   32'd1);
    resp_en = 1'b1;
    start_cmd(1'b0, 32'h0, 16'd0);
    check_eq("tmo_err_clr", {31'h0, err}, 32'h0);
    repeat (2) @(negedge clk);
`endif

    check_eq("done_width", max_run, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
